// File: rtl/gzip_job_arbiter.sv
// gzip_job_arbiter: job-granular round-robin sharing of one gzip core
// among N_REQ AXI4-Stream requesters, with in-order return routing.
// Ports:
//   clk, rst        : single clock, asynchronous active-high reset
//   i_t*            : requester streams, requester r at slice r
//   c_o_t*          : stream towards the compressor input
//   c_i_t*          : stream from the compressor output
//   o_tdata/tkeep/tlast : return data broadcast to all requesters
//   o_tvalid/o_tready   : per-requester return handshake
//   jobs_in_flight  : tag FIFO occupancy (jobs issued, not returned)
//   busy            : a job is being issued or jobs are outstanding
module gzip_job_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_BITS   = 512,
    parameter int ORDER_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_REQ*DATA_BITS-1:0]         i_tdata,
    input  logic [N_REQ*DATA_BITS/8-1:0]       i_tkeep,
    input  logic [N_REQ-1:0]                   i_tlast,
    input  logic [N_REQ-1:0]                   i_tvalid,
    output logic [N_REQ-1:0]                   i_tready,
    output logic [DATA_BITS-1:0]               c_o_tdata,
    output logic [DATA_BITS/8-1:0]             c_o_tkeep,
    output logic                               c_o_tlast,
    output logic                               c_o_tvalid,
    input  logic                               c_o_tready,
    input  logic [DATA_BITS-1:0]               c_i_tdata,
    input  logic [DATA_BITS/8-1:0]             c_i_tkeep,
    input  logic                               c_i_tlast,
    input  logic                               c_i_tvalid,
    output logic                               c_i_tready,
    output logic [DATA_BITS-1:0]               o_tdata,
    output logic [DATA_BITS/8-1:0]             o_tkeep,
    output logic                               o_tlast,
    output logic [N_REQ-1:0]                   o_tvalid,
    input  logic [N_REQ-1:0]                   o_tready,
    output logic [$clog2(ORDER_DEPTH+1)-1:0]   jobs_in_flight,
    output logic                               busy
);

    localparam int KW = DATA_BITS / 8;
    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(ORDER_DEPTH + 1);
    localparam int PW = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t        r_state;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_last_grant;
    logic [GW-1:0] r_tags [ORDER_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_found;
    logic [GW-1:0] w_pick;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_issue_hs;
    logic [GW-1:0] w_head;

    // Round-robin scan starting just after the last granted requester.
    always_comb begin : p_rr
        int            idx;
        logic [GW-1:0] sel;
        w_found = 1'b0;
        w_pick  = '0;
        idx     = 0;
        sel     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(r_last_grant) + i) % N_REQ;
            sel = GW'(idx);
            if (!w_found && i_tvalid[sel]) begin
                w_found = 1'b1;
                w_pick  = sel;
            end
        end
    end

    // Fullness uses the registered count: a same-cycle pop does not
    // free a slot for this cycle's grant.
    assign w_full  = (r_count == CW'(ORDER_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = (r_state == S_IDLE) && w_found && !w_full;
    assign w_head  = r_tags[r_rd_ptr];

    // Issue path: combinational mux on the registered grant.
    assign c_o_tdata  = i_tdata[int'(r_grant)*DATA_BITS +: DATA_BITS];
    assign c_o_tkeep  = i_tkeep[int'(r_grant)*KW +: KW];
    assign c_o_tlast  = i_tlast[r_grant];
    assign c_o_tvalid = (r_state == S_GRANT) && i_tvalid[r_grant];
    assign w_issue_hs = c_o_tvalid && c_o_tready;

    always_comb begin
        i_tready = '0;
        if (r_state == S_GRANT) begin
            i_tready[r_grant] = c_o_tready;
        end
    end

    // Return path: route to the requester at the head of the tag FIFO.
    always_comb begin
        o_tvalid   = '0;
        c_i_tready = 1'b0;
        if (!w_empty) begin
            o_tvalid[w_head] = c_i_tvalid;
            c_i_tready       = o_tready[w_head];
        end
    end

    assign w_pop   = c_i_tvalid && c_i_tready && c_i_tlast;
    assign o_tdata = c_i_tdata;
    assign o_tkeep = c_i_tkeep;
    assign o_tlast = c_i_tlast;

    assign jobs_in_flight = r_count;
    assign busy           = (r_state == S_GRANT) || !w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(N_REQ - 1);
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_push) begin
                        r_grant <= w_pick;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_issue_hs && c_o_tlast) begin
                        r_last_grant <= r_grant;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage needs no reset: only entries below r_count are read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tags[r_wr_ptr] <= w_pick;
        end
    end

endmodule

// File: tb/tb_gzip_job_arbiter.sv
// tb_gzip_job_arbiter: directed scoreboard bench for gzip_job_arbiter.
// Drivers feed requester/compressor queues; monitors pop expectations.
module tb_gzip_job_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int OD = 8;
    localparam int JW = $clog2(OD + 1);

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    typedef struct packed {
        logic [3:0] r;
        beat_t      b;
    } ret_t;

    logic              clk;
    logic              rst;
    logic [N*DW-1:0]   i_tdata;
    logic [N*KW-1:0]   i_tkeep;
    logic [N-1:0]      i_tlast;
    logic [N-1:0]      i_tvalid;
    logic [N-1:0]      i_tready;
    logic [DW-1:0]     c_o_tdata;
    logic [KW-1:0]     c_o_tkeep;
    logic              c_o_tlast;
    logic              c_o_tvalid;
    logic              c_o_tready;
    logic [DW-1:0]     c_i_tdata;
    logic [KW-1:0]     c_i_tkeep;
    logic              c_i_tlast;
    logic              c_i_tvalid;
    logic              c_i_tready;
    logic [DW-1:0]     o_tdata;
    logic [KW-1:0]     o_tkeep;
    logic              o_tlast;
    logic [N-1:0]      o_tvalid;
    logic [N-1:0]      o_tready;
    logic [JW-1:0]     jobs_in_flight;
    logic              busy;

    gzip_job_arbiter #(
        .N_REQ       (N),
        .DATA_BITS   (DW),
        .ORDER_DEPTH (OD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_tdata        (i_tdata),
        .i_tkeep        (i_tkeep),
        .i_tlast        (i_tlast),
        .i_tvalid       (i_tvalid),
        .i_tready       (i_tready),
        .c_o_tdata      (c_o_tdata),
        .c_o_tkeep      (c_o_tkeep),
        .c_o_tlast      (c_o_tlast),
        .c_o_tvalid     (c_o_tvalid),
        .c_o_tready     (c_o_tready),
        .c_i_tdata      (c_i_tdata),
        .c_i_tkeep      (c_i_tkeep),
        .c_i_tlast      (c_i_tlast),
        .c_i_tvalid     (c_i_tvalid),
        .c_i_tready     (c_i_tready),
        .o_tdata        (o_tdata),
        .o_tkeep        (o_tkeep),
        .o_tlast        (o_tlast),
        .o_tvalid       (o_tvalid),
        .o_tready       (o_tready),
        .jobs_in_flight (jobs_in_flight),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    beat_t src_q [N][$];
    beat_t cmp_q [$];
    beat_t exp_iss [$];
    ret_t  exp_ret [$];
    int    iss_cyc [$];
    int    ret_cyc [$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic beat_t mk(input int r, input int n, input int k,
                                 input int base);
        beat_t b;
        b.d = DW'((r << 24) | (base + k));
        b.k = KW'(k + 1);
        b.l = (k == n - 1);
        return b;
    endfunction

    task automatic src_job(input int r, input int n, input int base);
        for (int k = 0; k < n; k++) src_q[r].push_back(mk(r, n, k, base));
    endtask

    task automatic exp_job(input int r, input int n, input int base);
        for (int k = 0; k < n; k++) exp_iss.push_back(mk(r, n, k, base));
    endtask

    task automatic job(input int r, input int n, input int base);
        src_job(r, n, base);
        exp_job(r, n, base);
    endtask

    task automatic cmp_pkt(input int tag, input int n, input int base);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b = mk(tag + 8, n, k, base);
            cmp_q.push_back(b);
            exp_ret.push_back({4'(tag), b});
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic int src_left();
        int s = 0;
        for (int r = 0; r < N; r++) s += src_q[r].size();
        return s;
    endfunction

    task automatic wait_done(input string name, input bit issue_only);
        int t = 0;
        while (t < 400 && (src_left() != 0 || exp_iss.size() != 0 ||
               (!issue_only && (cmp_q.size() != 0 || exp_ret.size() != 0)))) begin
            tick(1);
            t++;
        end
        chk({name, "_timeout"}, 64'(t >= 400), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int r = 0; r < N; r++) src_q[r].delete();
        cmp_q.delete();
        exp_iss.delete();
        exp_ret.delete();
        tick(2);
        rst = 1'b0;
        tick(1);
        iss_cyc.delete();
        ret_cyc.delete();
    endtask

    // Source driver for requesters and compressor output.
    initial begin : drv
        logic [N-1:0] fire_i;
        logic         fire_c;
        i_tdata = '0; i_tkeep = '0; i_tlast = '0; i_tvalid = '0;
        c_i_tdata = '0; c_i_tkeep = '0; c_i_tlast = 1'b0; c_i_tvalid = 1'b0;
        forever begin
            @(negedge clk);
            drive();
            #1;
            fire_i = i_tvalid & i_tready;
            fire_c = c_i_tvalid & c_i_tready;
            @(posedge clk);
            #1;
            if (!rst) begin
                for (int r = 0; r < N; r++)
                    if (fire_i[r] && src_q[r].size() > 0) void'(src_q[r].pop_front());
                if (fire_c && cmp_q.size() > 0) void'(cmp_q.pop_front());
            end
            drive();
        end
    end

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            i_tvalid[r] = (src_q[r].size() > 0);
            if (src_q[r].size() > 0) begin
                i_tdata[r*DW +: DW] = src_q[r][0].d;
                i_tkeep[r*KW +: KW] = src_q[r][0].k;
                i_tlast[r]          = src_q[r][0].l;
            end
        end
        c_i_tvalid = (cmp_q.size() > 0);
        if (cmp_q.size() > 0) begin
            c_i_tdata = cmp_q[0].d;
            c_i_tkeep = cmp_q[0].k;
            c_i_tlast = cmp_q[0].l;
        end
    endtask

    // Monitor: compares every handshake against the scoreboard queues.
    initial begin : mon
        beat_t e;
        ret_t  er;
        int    r;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && c_o_tvalid && c_o_tready) begin
                if (exp_iss.size() == 0) begin
                    chk("iss_extra", 64'(c_o_tdata), 64'hdead);
                end else begin
                    e = exp_iss.pop_front();
                    chk("iss_beat", 64'({c_o_tdata, c_o_tkeep, c_o_tlast}), 64'(e));
                    iss_cyc.push_back(cyc);
                end
            end
            if (!rst && ((o_tvalid & o_tready) != '0)) begin
                chk("ret_onehot", 64'($onehot(o_tvalid)), 64'd1);
                r = 0;
                for (int i = N - 1; i >= 0; i--)
                    if (o_tvalid[i] && o_tready[i]) r = i;
                if (exp_ret.size() == 0) begin
                    chk("ret_extra", 64'(r), 64'hdead);
                end else begin
                    er = exp_ret.pop_front();
                    chk("ret_beat", 64'({4'(r), o_tdata, o_tkeep, o_tlast}), 64'(er));
                    ret_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int c0;
        int t;
        rst = 1'b1;
        c_o_tready = 1'b1;
        o_tready = '1;
        tick(2);
        chk("rst_i_tready", 64'(i_tready), 64'd0);
        chk("rst_o_tvalid", 64'(o_tvalid), 64'd0);
        chk("rst_c_o_tvalid", 64'(c_o_tvalid), 64'd0);
        chk("rst_c_i_tready", 64'(c_i_tready), 64'd0);
        chk("rst_jobs", 64'(jobs_in_flight), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick(1);

        // single requester, 3 beats in, 2 beats back
        c0 = cyc;
        job(0, 3, 'h100);
        tick(1);
        chk("t1_jobs_1", 64'(jobs_in_flight), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_done("t1_issue", 1'b1);
        chk("t1_first_beat_cyc", 64'(qat(iss_cyc, 0)), 64'(c0 + 1));
        chk("t1_last_beat_cyc", 64'(qat(iss_cyc, 2)), 64'(c0 + 3));
        chk("t1_jobs_held", 64'(jobs_in_flight), 64'd1);
        cmp_pkt(0, 2, 'h200);
        wait_done("t1_ret", 1'b0);
        chk("t1_ret_beats", 64'(ret_cyc.size()), 64'd2);
        chk("t1_jobs_0", 64'(jobs_in_flight), 64'd0);
        chk("t1_busy_0", 64'(busy), 64'd0);

        // round robin 0,1,3 from reset
        do_reset();
        c0 = cyc;
        src_job(0, 1, 'h300); src_job(0, 1, 'h301);
        src_job(1, 1, 'h310); src_job(1, 1, 'h311);
        src_job(3, 1, 'h330); src_job(3, 1, 'h331);
        exp_job(0, 1, 'h300); exp_job(1, 1, 'h310); exp_job(3, 1, 'h330);
        exp_job(0, 1, 'h301); exp_job(1, 1, 'h311); exp_job(3, 1, 'h331);
        wait_done("t2_issue", 1'b1);
        for (int i = 0; i < 6; i++)
            chk("t2_rr_cyc", 64'(qat(iss_cyc, i)), 64'(c0 + 1 + 2 * i));
        chk("t2_jobs_6", 64'(jobs_in_flight), 64'd6);
        cmp_pkt(0, 1, 'h340); cmp_pkt(1, 1, 'h341); cmp_pkt(3, 1, 'h342);
        cmp_pkt(0, 1, 'h343); cmp_pkt(1, 1, 'h344); cmp_pkt(3, 1, 'h345);
        wait_done("t2_ret", 1'b0);
        chk("t2_jobs_0", 64'(jobs_in_flight), 64'd0);

        // grant lock: req 2 arrives during beat 2 of req 1
        iss_cyc.delete();
        c0 = cyc;
        job(1, 4, 'h400);
        tick(2);
        job(2, 2, 'h420);
        wait_done("t3_issue", 1'b1);
        chk("t3_req1_last_cyc", 64'(qat(iss_cyc, 3)), 64'(c0 + 4));
        chk("t3_req2_first_cyc", 64'(qat(iss_cyc, 4)), 64'(c0 + 6));
        cmp_pkt(1, 2, 'h440); cmp_pkt(2, 1, 'h450);
        wait_done("t3_ret", 1'b0);

        // order depth: 9 jobs, only 8 issue until a return completes
        do_reset();
        src_job(0, 1, 'h500); src_job(0, 1, 'h501); src_job(0, 1, 'h502);
        src_job(1, 1, 'h510); src_job(1, 1, 'h511);
        src_job(2, 1, 'h520); src_job(2, 1, 'h521);
        src_job(3, 1, 'h530); src_job(3, 1, 'h531);
        exp_job(0, 1, 'h500); exp_job(1, 1, 'h510);
        exp_job(2, 1, 'h520); exp_job(3, 1, 'h530);
        exp_job(0, 1, 'h501); exp_job(1, 1, 'h511);
        exp_job(2, 1, 'h521); exp_job(3, 1, 'h531);
        exp_job(0, 1, 'h502);
        tick(30);
        chk("t4_jobs_8", 64'(jobs_in_flight), 64'd8);
        chk("t4_grants_8", 64'(iss_cyc.size()), 64'd8);
        chk("t4_ninth_waiting", 64'(src_q[0].size()), 64'd1);
        chk("t4_c_o_idle", 64'(c_o_tvalid), 64'd0);
        cmp_pkt(0, 1, 'h600);
        wait_done("t4_ninth", 1'b1);
        chk("t4_ninth_cyc", 64'(qat(iss_cyc, 8)), 64'(qat(ret_cyc, 0) + 2));
        cmp_pkt(1, 1, 'h601); cmp_pkt(2, 1, 'h602); cmp_pkt(3, 1, 'h603);
        cmp_pkt(0, 1, 'h604); cmp_pkt(1, 1, 'h605); cmp_pkt(2, 1, 'h606);
        cmp_pkt(3, 1, 'h607); cmp_pkt(0, 1, 'h608);
        wait_done("t4_ret", 1'b0);
        chk("t4_jobs_0", 64'(jobs_in_flight), 64'd0);

        // return routing with backpressure, tags [2,0]
        job(2, 1, 'h700);
        job(0, 1, 'h701);
        wait_done("t5_issue", 1'b1);
        chk("t5_jobs_2", 64'(jobs_in_flight), 64'd2);
        cmp_pkt(2, 4, 'h800);
        cmp_pkt(0, 2, 'h810);
        for (int i = 0; i < 12; i++) begin
            o_tready[2] = (i % 2 == 0);
            #1;
            if (i < 4) begin
                chk("t5_c_i_tready", 64'(c_i_tready), 64'(o_tready[2]));
                chk("t5_o_tvalid0", 64'(o_tvalid[0]), 64'd0);
            end
            tick(1);
        end
        o_tready = '1;
        wait_done("t5_ret", 1'b0);

        // reset mid-job with 3 tags queued
        o_tready = '0;
        job(1, 1, 'h900);
        job(2, 1, 'h910);
        job(3, 5, 'h920);
        cmp_pkt(1, 1, 'ha00);
        t = 0;
        while (src_q[3].size() != 4 && t < 60) begin
            tick(1);
            t++;
        end
        chk("t6_reach_beat2", 64'(t >= 60), 64'd0);
        chk("t6_pre_jobs", 64'(jobs_in_flight), 64'd3);
        chk("t6_pre_i_tready", 64'(i_tready), 64'b1000);
        chk("t6_pre_o_tvalid", 64'(o_tvalid), 64'b0010);
        rst = 1'b1;
        #1;
        chk("t6_i_tready", 64'(i_tready), 64'd0);
        chk("t6_c_o_tvalid", 64'(c_o_tvalid), 64'd0);
        chk("t6_o_tvalid", 64'(o_tvalid), 64'd0);
        chk("t6_c_i_tready", 64'(c_i_tready), 64'd0);
        chk("t6_jobs", 64'(jobs_in_flight), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        do_reset();
        o_tready = '1;
        src_job(3, 1, 'hb30);
        src_job(0, 1, 'hb00);
        exp_job(0, 1, 'hb00);
        exp_job(3, 1, 'hb30);
        wait_done("t6_issue", 1'b1);
        cmp_pkt(0, 1, 'hc00);
        cmp_pkt(3, 1, 'hc30);
        wait_done("t6_ret", 1'b0);
        chk("t6_end_jobs", 64'(jobs_in_flight), 64'd0);
        chk("t6_end_busy", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
